// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit with HI/LO result registers.
// Ports: clk, reset_n, start, op, operand_a/b in; busy, done, div_zero, hi, lo out.
module mult_div_unit #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [ITER_W-1:0] LAST = ITER_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [ITER_W-1:0]  cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;
  logic               dz;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add;
  logic [WIDTH:0]     trial;
  logic [WIDTH+1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    mag_a = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    mag_b = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
    // Shift-add: p[63:32] accumulates, p[31:0] holds remaining multiplier bits.
    add   = {1'b0, p[2*WIDTH-1:WIDTH]}
          + (p[0] ? {1'b0, m} : '0);
    // Restoring divide: p[63:32] is partial remainder, p[31:0] dividend/quotient.
    trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff  = {1'b0, trial} - {2'b00, m};
    ge    = ~diff[WIDTH+1];
    prod  = neg_q ? (~p + 1'b1) : p;
    quo   = neg_q ? (~p[WIDTH-1:0] + 1'b1) : p[WIDTH-1:0];
    rem   = neg_r ? (~p[2*WIDTH-1:WIDTH] + 1'b1)
                  : p[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      p        <= '0;
      m        <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            neg_q    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            neg_r    <= operand_a[WIDTH-1];
            is_div   <= op;
            div_zero <= 1'b0;
            cnt      <= '0;
            dz       <= op && (operand_b == '0);
            if (op) begin
              m <= mag_b;
              p <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              m <= mag_a;
              p <= {{WIDTH{1'b0}}, mag_b};
            end
            if (!op)
              state <= S_MULT;
            else if (operand_b == '0)
              state <= S_FIN;
            else
              state <= S_DIV;
          end
        end
        S_MULT: begin
          p   <= {add, p[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_FIN;
        end
        S_DIV: begin
          if (ge)
            p <= {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
          else
            p <= {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_FIN;
        end
        S_FIN: begin
          if (dz) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Drives at #1 after rising edges; samples at #1 after rising edges.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  int cycles;
  int busy_cnt;

  mult_div_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; busy sampled each cycle.
  task automatic wait_done();
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    if (!done) cycles = 999;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b exp=0", done);
    end
    total++;
    if (div_zero !== 1'b0) begin
      bad++; $display("FAIL rst_dz got=%b exp=0", div_zero);
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++; $display("FAIL rst_hilo got=%h exp=0", {hi, lo});
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult_basic();
    issue(1'b0, 32'd7, 32'hFFFFFFFD);
    wait_done();
    total++;
    if (cycles !== 33) begin
      bad++; $display("FAIL mul_lat got=%0d exp=33", cycles);
    end
    total++;
    if (busy_cnt !== 33) begin
      bad++; $display("FAIL mul_busy got=%0d exp=33", busy_cnt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL mul_busy_done got=%b exp=0", busy);
    end
    total++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      bad++; $display("FAIL mul_7x-3 got=%h exp=ffffffffffffffeb", {hi, lo});
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL mul_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_mult_corner();
    issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done();
    total++;
    if ({hi, lo} !== 64'h3FFFFFFF_00000001) begin
      bad++; $display("FAIL mul_max got=%h exp=3fffffff00000001", {hi, lo});
    end
    issue(1'b0, 32'h80000000, 32'h80000000);
    wait_done();
    total++;
    if ({hi, lo} !== 64'h40000000_00000000) begin
      bad++; $display("FAIL mul_min got=%h exp=4000000000000000", {hi, lo});
    end
  endtask

  task automatic test_div();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] ex [3];
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
    ex[0] = 64'hFFFFFFFF_FFFFFFFD;
    va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE;
    ex[1] = 64'h00000001_FFFFFFFD;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF;
    ex[2] = 64'h00000000_80000000;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, va[i], vb[i]);
      wait_done();
      total++;
      if ({hi, lo} !== ex[i] || cycles !== 33 || div_zero !== 1'b0) begin
        bad++;
        $display("FAIL div_%0d got=%h lat=%0d dz=%b exp=%h lat=33 dz=0",
                 i, {hi, lo}, cycles, div_zero, ex[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    issue(1'b1, 32'h451, 32'h20);
    wait_done();
    total++;
    if ({hi, lo} !== 64'h00000011_00000022) begin
      bad++; $display("FAIL div_prep got=%h exp=0000001100000022", {hi, lo});
    end
    issue(1'b1, 32'd5, 32'd0);
    wait_done();
    total++;
    if (cycles !== 1) begin
      bad++; $display("FAIL dz_lat got=%0d exp=1", cycles);
    end
    total++;
    if (div_zero !== 1'b1) begin
      bad++; $display("FAIL dz_flag got=%b exp=1", div_zero);
    end
    total++;
    if ({hi, lo} !== 64'h00000011_00000022) begin
      bad++; $display("FAIL dz_hold got=%h exp=0000001100000022", {hi, lo});
    end
    @(posedge clk);
    #1;
    total++;
    if (div_zero !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL dz_sticky got=%b/%b exp=1/0", div_zero, done);
    end
    issue(1'b0, 32'd3, 32'd4);
    total++;
    if (div_zero !== 1'b0) begin
      bad++; $display("FAIL dz_clear got=%b exp=0", div_zero);
    end
    wait_done();
    total++;
    if ({hi, lo} !== 64'd12) begin
      bad++; $display("FAIL dz_next got=%h exp=c", {hi, lo});
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'd100, 32'd200);
    cycles = 0;
    while (!done && cycles < 100) begin
      if (cycles == 9) begin
        start = 1'b1;
        op = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    if (!done) cycles = 999;
    total++;
    if (cycles !== 33 || {hi, lo} !== 64'd20000) begin
      bad++;
      $display("FAIL ignore_start lat=%0d got=%h exp lat=33 val=4e20",
               cycles, {hi, lo});
    end
    issue(1'b0, 32'd3, 32'hFFFFFFFB);
    wait_done();
    total++;
    if (cycles !== 33 || {hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      bad++;
      $display("FAIL b2b lat=%0d got=%h exp lat=33 val=fffffffffffffff1",
               cycles, {hi, lo});
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b hilo=%h exp 0/0/0",
               busy, done, {hi, lo});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'd3, 32'd4);
    wait_done();
    total++;
    if (cycles !== 33 || {hi, lo} !== 64'd12) begin
      bad++;
      $display("FAIL post_reset lat=%0d got=%h exp lat=33 val=c",
               cycles, {hi, lo});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_mult_basic();
    test_mult_corner();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
